// File: rtl/mips32_pkg.sv
// Shared types for the MIPS32 hazard controller: opcodes, instruction field
// positions, interlock FSM states and the scoreboard entry layout.
package mips32_pkg;

    typedef enum logic [5:0] {
        OP_ADD   = 6'b000000,
        OP_SUB   = 6'b000001,
        OP_AND   = 6'b000010,
        OP_OR    = 6'b000011,
        OP_SLT   = 6'b000100,
        OP_MUL   = 6'b000101,
        OP_LW    = 6'b001000,
        OP_SW    = 6'b001001,
        OP_ADDI  = 6'b001010,
        OP_SUBI  = 6'b001011,
        OP_SLTI  = 6'b001100,
        OP_BNEQZ = 6'b001101,
        OP_BEQZ  = 6'b001110,
        OP_HLT   = 6'b111111
    } opcode_e;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic       v;
        logic [4:0] r;
    } sb_entry_t;

endpackage

// File: rtl/mips32_hazard_ctrl_if.sv
// ID-stage inputs and pipeline enable outputs exchanged between the datapath
// (master) and the hazard controller (slave).
interface mips32_hazard_ctrl_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   id_valid;
    logic [31:0]            id_ir;
    logic                   ex_branch_taken;
    logic                   pc_we;
    logic                   ifid_we;
    logic                   ifid_flush;
    logic                   id_bubble;
    logic                   halted;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_ir, ex_branch_taken,
        input  pc_we, ifid_we, ifid_flush, id_bubble, halted, stall_cnt
    );

    modport slave (
        input  id_valid, id_ir, ex_branch_taken,
        output pc_we, ifid_we, ifid_flush, id_bubble, halted, stall_cnt
    );
endinterface

// File: rtl/mips32_id_decode.sv
// Combinational decode of the ID-stage instruction into register usage:
// which sources are read, which destination is written, and HLT detection.
module mips32_id_decode
    import mips32_pkg::*;
(
    input  logic [31:0] i_ir,
    output logic        use_rs,
    output logic        use_rt,
    output logic        has_dest,
    output logic [4:0]  dest,
    output logic        is_hlt
);

    opcode_e    w_op;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic       w_unused_ir;

    assign w_op        = opcode_e'(i_ir[OPC_MSB:OPC_LSB]);
    assign w_rt        = i_ir[RT_MSB:RT_LSB];
    assign w_rd        = i_ir[RD_MSB:RD_LSB];
    assign w_unused_ir = ^i_ir[RD_LSB-1:0];

    always_comb begin
        use_rs   = 1'b0;
        use_rt   = 1'b0;
        has_dest = 1'b0;
        dest     = 5'd0;
        is_hlt   = 1'b0;
        case (w_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
                use_rs   = 1'b1;
                use_rt   = 1'b1;
                has_dest = 1'b1;
                dest     = w_rd;
            end
            OP_ADDI, OP_SUBI, OP_SLTI, OP_LW: begin
                use_rs   = 1'b1;
                has_dest = 1'b1;
                dest     = w_rt;
            end
            OP_SW: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            OP_BNEQZ, OP_BEQZ: begin
                use_rs = 1'b1;
            end
            OP_HLT: begin
                is_hlt = 1'b1;
            end
            // Unknown opcodes read and write nothing, so they never interlock.
            default: ;
        endcase
    end

endmodule

// File: rtl/mips32_hazard_ctrl.sv
// Interlock controller: tracks destinations in EX/MEM/WB, stalls IF/ID on RAW
// hazards, flushes on taken branches and drains the pipe into a halt on HLT.
module mips32_hazard_ctrl
    import mips32_pkg::*;
#(
    parameter bit FWD_WB      = 1'b1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                 clk_1,
    input  logic                 rst,
    mips32_hazard_ctrl_if.slave  bus
);

    sb_entry_t              r_sb_ex;
    sb_entry_t              r_sb_mem;
    sb_entry_t              r_sb_wb;
    hz_state_e              r_state;
    hz_state_e              w_state_nxt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic       w_use_rs;
    logic       w_use_rt;
    logic       w_has_dest;
    logic [4:0] w_dest;
    logic       w_is_hlt;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_hazard;
    logic       w_pc_we;
    logic       w_ifid_we;
    logic       w_ifid_flush;
    logic       w_id_bubble;
    logic       w_halted;
    logic       w_stall_inc;
    logic       w_sb_empty;
    sb_entry_t  w_sb_ex_nxt;

    mips32_id_decode u_decode (
        .i_ir     (bus.id_ir),
        .use_rs   (w_use_rs),
        .use_rt   (w_use_rt),
        .has_dest (w_has_dest),
        .dest     (w_dest),
        .is_hlt   (w_is_hlt)
    );

    assign w_rs = bus.id_ir[RS_MSB:RS_LSB];
    assign w_rt = bus.id_ir[RT_MSB:RT_LSB];

    // With a write-before-read register file the WB producer is already visible.
    function automatic logic src_hit(
        input logic [4:0] r,
        input sb_entry_t  ex,
        input sb_entry_t  mem,
        input sb_entry_t  wb
    );
        return (r != 5'd0) &&
               ((ex.v  && (ex.r  == r)) ||
                (mem.v && (mem.r == r)) ||
                (!FWD_WB && wb.v && (wb.r == r)));
    endfunction

    assign w_hazard = bus.id_valid &
                      ((w_use_rs & src_hit(w_rs, r_sb_ex, r_sb_mem, r_sb_wb)) |
                       (w_use_rt & src_hit(w_rt, r_sb_ex, r_sb_mem, r_sb_wb)));

    assign w_sb_empty = ~(r_sb_ex.v | r_sb_mem.v | r_sb_wb.v);

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_we      = 1'b1;
        w_ifid_we    = 1'b1;
        w_ifid_flush = 1'b0;
        w_id_bubble  = 1'b0;
        w_halted     = 1'b0;
        w_stall_inc  = 1'b0;
        case (r_state)
            RUN: begin
                if (bus.ex_branch_taken) begin
                    // Wrong-path instruction in ID is squashed, HLT included.
                    w_ifid_flush = 1'b1;
                    w_id_bubble  = 1'b1;
                end else if (w_hazard) begin
                    w_pc_we     = 1'b0;
                    w_ifid_we   = 1'b0;
                    w_id_bubble = 1'b1;
                    w_stall_inc = 1'b1;
                end else if (bus.id_valid && w_is_hlt) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_pc_we     = 1'b0;
                w_ifid_we   = 1'b0;
                w_id_bubble = 1'b1;
                if (w_sb_empty) begin
                    w_state_nxt = HALTED;
                end
            end
            HALTED: begin
                w_pc_we     = 1'b0;
                w_ifid_we   = 1'b0;
                w_id_bubble = 1'b1;
                w_halted    = 1'b1;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // R0 is never recorded, so a write to it can never create an interlock.
    always_comb begin
        w_sb_ex_nxt.v = bus.id_valid & ~w_id_bubble & w_has_dest & (w_dest != 5'd0);
        w_sb_ex_nxt.r = w_dest;
    end

    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            r_sb_ex     <= '0;
            r_sb_mem    <= '0;
            r_sb_wb     <= '0;
            r_state     <= RUN;
            r_stall_cnt <= '0;
        end else begin
            r_sb_ex  <= w_sb_ex_nxt;
            r_sb_mem <= r_sb_ex;
            r_sb_wb  <= r_sb_mem;
            r_state  <= w_state_nxt;
            if (w_stall_inc && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign bus.pc_we      = w_pc_we;
    assign bus.ifid_we    = w_ifid_we;
    assign bus.ifid_flush = w_ifid_flush;
    assign bus.id_bubble  = w_id_bubble;
    assign bus.halted     = w_halted;
    assign bus.stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_mips32_hazard_ctrl.sv
// Bench: two controllers (write-before-read WB and not) share one ID stimulus
// stream and are compared against an issue-history reference model.
module tb_mips32_hazard_ctrl;

    logic clk_1 = 1'b0;
    logic rst;
    always #5 clk_1 = ~clk_1;

    mips32_hazard_ctrl_if #(.STALL_CNT_W(16)) if_a ();
    mips32_hazard_ctrl_if #(.STALL_CNT_W(16)) if_b ();

    assign if_b.id_valid        = if_a.id_valid;
    assign if_b.id_ir           = if_a.id_ir;
    assign if_b.ex_branch_taken = if_a.ex_branch_taken;

    mips32_hazard_ctrl #(.FWD_WB(1'b1), .STALL_CNT_W(16)) u_a (
        .clk_1 (clk_1),
        .rst   (rst),
        .bus   (if_a.slave)
    );

    mips32_hazard_ctrl #(.FWD_WB(1'b0), .STALL_CNT_W(16)) u_b (
        .clk_1 (clk_1),
        .rst   (rst),
        .bus   (if_b.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Per variant: dests issued in the last three slots (0 = nothing), state, stalls.
    int hist [2][3];
    int st   [2];
    int cnt  [2];
    bit last_bub_a;

    function automatic logic [31:0] enc(input int op, input int rs, input int rt, input int rd);
        return {6'(op), 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic void ref_decode(input logic [31:0] ir, output int s1, output int s2,
                                       output int d, output bit hlt);
        int op;
        int rs;
        int rt;
        int rd;
        op = int'(ir[31:26]);
        rs = int'(ir[25:21]);
        rt = int'(ir[20:16]);
        rd = int'(ir[15:11]);
        s1 = 0; s2 = 0; d = 0; hlt = 1'b0;
        if (op <= 5) begin s1 = rs; s2 = rt; d = rd; end
        else if (op == 8 || op == 10 || op == 11 || op == 12) begin s1 = rs; d = rt; end
        else if (op == 9) begin s1 = rs; s2 = rt; end
        else if (op == 13 || op == 14) s1 = rs;
        else if (op == 63) hlt = 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs(input int k);
        if (k == 0)
            return 32'({if_a.pc_we, if_a.ifid_we, if_a.ifid_flush, if_a.id_bubble, if_a.halted});
        return 32'({if_b.pc_we, if_b.ifid_we, if_b.ifid_flush, if_b.id_bubble, if_b.halted});
    endfunction

    function automatic logic [31:0] cnt_of(input int k);
        return (k == 0) ? 32'(if_a.stall_cnt) : 32'(if_b.stall_cnt);
    endfunction

    task automatic step(input bit v, input logic [31:0] ir, input bit br);
        int s1, s2, d;
        bit hlt;
        @(negedge clk_1);
        if_a.id_valid        = v;
        if_a.id_ir           = ir;
        if_a.ex_branch_taken = br;
        #2;
        ref_decode(ir, s1, s2, d, hlt);
        for (int k = 0; k < 2; k++) begin
            int   depth;
            bit   haz;
            bit   run;
            bit   issue;
            logic [4:0] e;
            depth = (k == 0) ? 2 : 3;
            haz = 1'b0;
            for (int j = 0; j < depth; j++)
                if (hist[k][j] != 0 && (hist[k][j] == s1 || hist[k][j] == s2)) haz = 1'b1;
            haz = haz & v;
            run = (st[k] == 0);
            if (!run)      e = {4'b0001, st[k] == 2};
            else if (br)   e = 5'b11110;
            else if (haz)  e = 5'b00010;
            else           e = 5'b11000;
            if (k == 0) begin
                chk("ctl_fwd1", outs(0), 32'(e));
                chk("cnt_fwd1", cnt_of(0), 32'(cnt[0]));
                last_bub_a = e[1];
            end else begin
                chk("ctl_fwd0", outs(1), 32'(e));
                chk("cnt_fwd0", cnt_of(1), 32'(cnt[1]));
            end
            issue = run && v && !br && !haz;
            if (run && !br && haz && cnt[k] < 65535) cnt[k]++;
            if (issue && hlt) st[k] = 1;
            else if (st[k] == 1 && hist[k][0] == 0 && hist[k][1] == 0 && hist[k][2] == 0) st[k] = 2;
            hist[k][2] = hist[k][1];
            hist[k][1] = hist[k][0];
            hist[k][0] = issue ? d : 0;
        end
    endtask

    // Reset is asserted between edges; outputs must reflect it without a clock.
    task automatic apply_reset(input string tag);
        if_a.id_valid        = 1'b0;
        if_a.ex_branch_taken = 1'b0;
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk(tag, outs(k), 32'(5'b11000));
            chk(tag, cnt_of(k), 32'd0);
            st[k] = 0; cnt[k] = 0;
            for (int j = 0; j < 3; j++) hist[k][j] = 0;
        end
        @(posedge clk_1);
        @(negedge clk_1);
        rst = 1'b1;
    endtask

    function automatic logic [31:0] rand_ir();
        int op;
        case ($urandom_range(0, 11))
            0: op = 0;  1: op = 1;  2: op = 5;  3: op = 8;
            4: op = 9;  5: op = 10; 6: op = 12; 7: op = 13;
            8: op = 14; 9: op = 11; 10: op = 3; default: op = 21;
        endcase
        return enc(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
    endfunction

    initial begin
        logic [31:0] ir;
        bit   br;
        bit   v;
        int   n;
        if_a.id_valid        = 1'b0;
        if_a.id_ir           = 32'd0;
        if_a.ex_branch_taken = 1'b0;
        rst = 1'b1;
        #12;
        apply_reset("reset_init");

        // Producer, producer, consumer: stalls 2 (WB write-before-read) vs 3.
        step(1, enc(10, 0, 1, 0), 0);
        step(1, enc(10, 0, 2, 0), 0);
        for (int i = 0; i < 4; i++) step(1, enc(0, 1, 2, 4), 0);
        chk("b2b_stalls_fwd1", cnt_of(0), 32'd2);
        chk("b2b_stalls_fwd0", cnt_of(1), 32'd3);

        // Independent stream, R0 writes/reads and SW with no destination.
        step(1, enc(10, 0, 1, 0), 0);
        step(1, enc(10, 0, 2, 0), 0);
        step(1, enc(10, 0, 3, 0), 0);
        step(1, enc(10, 0, 0, 0), 0);
        step(1, enc(0, 0, 0, 5), 0);
        step(0, 32'd0, 0);
        step(0, 32'd0, 0);
        step(0, 32'd0, 0);
        step(1, enc(9, 0, 6, 0), 0);
        step(1, enc(0, 6, 6, 7), 0);
        chk("nostall_fwd1", cnt_of(0), 32'd2);
        chk("nostall_fwd0", cnt_of(1), 32'd3);

        // Taken branch overrides a hazarding ADD in ID.
        step(1, enc(10, 0, 6, 0), 0);
        step(1, enc(0, 6, 6, 7), 1);
        chk("br_flush", {29'd0, if_a.ifid_flush, if_a.id_bubble, if_a.pc_we}, 32'd7);
        step(0, 32'd0, 0);
        chk("br_cnt_fwd1", cnt_of(0), 32'd2);

        // Randomised stream; stalled instructions stay in ID as the real IF/ID would.
        ir = rand_ir();
        br = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!(last_bub_a && !br)) ir = rand_ir();
            br = ($urandom_range(0, 9) == 0);
            v  = ($urandom_range(0, 7) != 0);
            step(v, ir, br);
        end

        // HLT drain: halted rises three edges after HLT leaves ID.
        for (int i = 0; i < 3; i++) step(0, 32'd0, 0);
        step(1, enc(10, 0, 3, 0), 0);
        step(1, enc(63, 0, 0, 0), 0);
        n = 0;
        for (int i = 1; i <= 10 && n == 0; i++) begin
            step(0, 32'd0, 0);
            if (if_a.halted === 1'b1) n = i;
        end
        chk("hlt_latency", 32'(n - 1), 32'd3);
        step(1, enc(10, 0, 1, 0), 0);
        step(1, enc(0, 1, 1, 2), 1);
        apply_reset("reset_halted");

        // Reset while draining, then a dependent pair must stall normally.
        step(1, enc(10, 0, 3, 0), 0);
        step(1, enc(63, 0, 0, 0), 0);
        step(0, 32'd0, 0);
        chk("in_drain", {31'd0, if_a.pc_we}, 32'd0);
        apply_reset("reset_drain");
        step(1, enc(10, 0, 1, 0), 0);
        for (int i = 0; i < 3; i++) step(1, enc(0, 1, 1, 2), 0);
        step(0, 32'd0, 0);
        chk("post_reset_fwd1", cnt_of(0), 32'd2);
        chk("post_reset_fwd0", cnt_of(1), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
